// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU front end and core control.
// Holds the instruction word field widths, the sequencer state encoding and
// the opcode constants decoded by the core's control FSM.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned INSTR_W  = 12;
    localparam int unsigned WORD_W   = OPCODE_W + INSTR_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StHalt  = 2'd3
    } seq_state_e;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_ADD = 4'h1;
    localparam opcode_t OP_SUB = 4'h2;
    localparam opcode_t OP_AND = 4'h3;
    localparam opcode_t OP_OR  = 4'h4;
    localparam opcode_t OP_XOR = 4'h5;
    localparam opcode_t OP_SHL = 4'h6;
    localparam opcode_t OP_SHR = 4'h7;
    localparam opcode_t OP_LD  = 4'h8;
    localparam opcode_t OP_ST  = 4'h9;
    localparam opcode_t OP_JMP = 4'hA;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// Ports:
//   clk, rstn        clock (rising edge), async active-low reset
//   push, wdata      write request and data; ignored when full unless popping
//   pop              read request; ignored when empty
//   rdata            current head word (valid while !empty)
//   full, empty      occupancy flags
//   count            occupancy, 0..DEPTH
module instr_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rptr_q];

    // A push while full is still accepted when a pop frees the head slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Front-end scheduler for the bit-serial CPU core. Buffers switch-entered
// instruction words and issues them to the core one at a time, waiting for
// the core's completion pulse between issues, with free-run / single-step
// control and a completion watchdog.
// Ports:
//   clk, rstn               clock (rising edge), async active-low reset
//   sw_data                 instruction word from switches {opcode, instr}
//   load_btn                pulse: push sw_data into the FIFO
//   run_btn                 pulse: toggle run, or request one step in step mode
//   step_mode               level: 1 = single-step
//   core_done               pulse: core finished the current instruction
//   clr_err                 pulse: clear sticky errors, leave HALT
//   opcode, instr           fields of the last issued word
//   inst_done               one-cycle issue strobe
//   running                 free-run enable
//   fifo_count/full/empty   FIFO occupancy
//   err_ovf, err_timeout    sticky error flags
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [WORD_W-1:0]      sw_data,
    input  logic                   load_btn,
    input  logic                   run_btn,
    input  logic                   step_mode,
    input  logic                   core_done,
    input  logic                   clr_err,
    output logic [OPCODE_W-1:0]    opcode,
    output logic [INSTR_W-1:0]     instr,
    output logic                   inst_done,
    output logic                   running,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   err_ovf,
    output logic                   err_timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    seq_state_e          state_q, state_d;
    logic                running_q, running_d;
    logic                step_req_q, step_req_d;
    logic                step_mode_q;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_timeout_q, err_timeout_d;
    logic [WORD_W-1:0]   head;
    logic                fifo_pop;
    logic                go;

    assign fifo_pop = (state_q == StIssue);

    instr_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (load_btn),
        .wdata (sw_data),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign go = (running_q | step_req_q) & ~fifo_empty;

    always_comb begin
        state_d       = state_q;
        running_d     = running_q;
        step_req_d    = step_req_q;
        opcode_d      = opcode_q;
        instr_d       = instr_q;
        wd_d          = wd_q;
        err_ovf_d     = err_ovf_q;
        err_timeout_d = err_timeout_q;

        if (step_mode) begin
            running_d = 1'b0;
        end else if (run_btn) begin
            running_d = ~running_q;
        end

        // A mode change drops any pending step; a fresh request beats consumption.
        if (step_mode != step_mode_q) begin
            step_req_d = 1'b0;
        end else begin
            if (state_q == StIssue)     step_req_d = 1'b0;
            if (step_mode && run_btn)   step_req_d = 1'b1;
        end

        // Clear first so an error raised in the same cycle is not lost.
        if (clr_err) begin
            err_ovf_d     = 1'b0;
            err_timeout_d = 1'b0;
        end
        if (load_btn && fifo_full && !fifo_pop) begin
            err_ovf_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d  = StIssue;
                    opcode_d = head[WORD_W-1 -: OPCODE_W];
                    instr_d  = head[INSTR_W-1:0];
                end
            end
            StIssue: begin
                state_d = StWait;
                wd_d    = '0;
            end
            StWait: begin
                if (core_done) begin
                    state_d = StIdle;
                end else if (wd_q == WD_LAST) begin
                    state_d       = StHalt;
                    err_timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            StHalt: begin
                if (clr_err) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            running_q     <= 1'b0;
            step_req_q    <= 1'b0;
            step_mode_q   <= 1'b0;
            opcode_q      <= '0;
            instr_q       <= '0;
            wd_q          <= '0;
            err_ovf_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            running_q     <= running_d;
            step_req_q    <= step_req_d;
            step_mode_q   <= step_mode;
            opcode_q      <= opcode_d;
            instr_q       <= instr_d;
            wd_q          <= wd_d;
            err_ovf_q     <= err_ovf_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign opcode      = opcode_q;
    assign instr       = instr_q;
    assign inst_done   = (state_q == StIssue);
    assign running     = running_q;
    assign err_ovf     = err_ovf_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Front-end scheduler for the bit-serial CPU core.
- Captures 16-bit instruction words (4-bit opcode, 12-bit operand field) from board switches into a small FIFO on each load button edge.
- Issues words to the core one at a time:
  - presents opcode/instr;
  - pulses inst_done;
  - waits for the core's end-of-instruction pulse before issuing the next.
- Supports free-run and single-step modes and a completion watchdog.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2).
- TIMEOUT_CYC, 64, maximum cycles in WAIT before watchdog fault (≥ 8 bits × worst-case opcode cycles).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- sw_data  input  16  instruction word; [15:12]=opcode, [11:0]=instr.
- load_btn  input  1  one-cycle debounced edge pulse: push sw_data.
- run_btn  input  1  one-cycle edge pulse: toggle run (step_mode=0) or request one issue (step_mode=1).
- step_mode  input  1  level; 1 = single-step.
- core_done  input  1  one-cycle pulse from core control at instruction completion.
- clr_err  input  1  one-cycle pulse: clear sticky flags, leave HALT.
- opcode  output  4  opcode of the last issued word.
- instr  output  12  operand field of the last issued word.
- inst_done  output  1  one-cycle issue strobe to the core.
- running  output  1  free-run enable state.
- fifo_count  output  $clog2(DEPTH)+1  occupancy.
- fifo_full  output  1  count==DEPTH.
- fifo_empty  output  1  count==0.
- err_ovf  output  1  sticky: load while full.
- err_timeout  output  1  sticky: watchdog expired.

Behaviour:
- Reset (async, rstn=0):
  - all outputs 0 (fifo_empty=1);
  - FIFO pointers and count 0;
  - state IDLE;
  - step_req 0.
  - Reset mid-WAIT abandons the instruction; no inst_done after release until a new go.
- FIFO:
  - Push on load_btn when not full; occupancy visible the next cycle.
  - Push when full: word dropped, err_ovf←1.
  - Push and pop in the same cycle: both occur, count unchanged. When full, a simultaneous push and pop is accepted, with no overflow.
  - Pointers wrap modulo DEPTH.
- Run control:
  - step_mode=0: run_btn toggles running.
  - step_mode=1: run_btn sets step_req; running is forced to 0.
  - step_req is held until consumed by an issue.
  - Toggling step_mode clears step_req.
- FSM, states IDLE, ISSUE, WAIT, HALT:
  - IDLE: go = (running | step_req) & !fifo_empty. If go, next state is ISSUE.
  - ISSUE, exactly one cycle:
    - inst_done=1;
    - opcode/instr loaded from the FIFO head on entry and held until the next issue;
    - FIFO pop;
    - step_req←0;
    - next state WAIT;
    - watchdog counter cleared.
  - WAIT:
    - watchdog increments each cycle;
    - core_done → IDLE;
    - counter reaching TIMEOUT_CYC-1 without core_done → err_timeout←1, HALT;
    - core_done in the same cycle as expiry → core_done wins, IDLE.
  - HALT: no issue; only clr_err (→IDLE) or reset exits.
  - core_done outside WAIT is ignored.
- clr_err clears err_ovf and err_timeout in any state.
- Latency:
  - run_btn at cycle N with FIFO non-empty and state IDLE → inst_done high at N+2.
  - Back-to-back in free run: core_done at M → inst_done at M+2.
- Stopping free run while in WAIT: the current instruction completes; no further issue.
- Run or step with an empty FIFO: stay in IDLE. A pending step_req persists and issues on the first later push (step_req is latched, not dropped).

Decomposition:
- Shared cpu_pkg holds:
  - OPCODE_W=4, INSTR_W=12;
  - the sequencer state encoding (IDLE, ISSUE, WAIT, HALT);
  - opcode constants shared with the core's control FSM.
- One sub-module: instr_fifo. This is a synchronous FIFO parameterised by WIDTH and DEPTH, with a push/pop/full/empty/count interface, async active-low reset and first-word-fall-through head output.
- The FSM, run control and watchdog stay in instr_sequencer.

Test Plan:
- Push 0x1A5C, 0x2003, 0x30FF; pulse run_btn, with core_done pulsed 20 cycles after each inst_done:
  - three inst_done pulses;
  - opcode/instr = 1/0xA5C, 2/0x003, 3/0x0FF in order;
  - fifo_empty=1 at the end;
  - running stays 1.
- Push DEPTH+1 words:
  - fifo_full=1, count=DEPTH;
  - err_ovf=1;
  - ninth word absent on drain;
  - clr_err → err_ovf=0.
- step_mode=1, 2 words loaded, one run_btn → exactly one inst_done. A second run_btn pulsed during WAIT → second inst_done 2 cycles after the first core_done.
- Issue with core_done withheld:
  - err_timeout=1 and state HALT after TIMEOUT_CYC cycles in WAIT;
  - no further inst_done;
  - clr_err → resumes the next word.
- Full FIFO with load_btn in the ISSUE pop cycle → count unchanged, err_ovf=0, new word issued last.
- rstn low during WAIT → all outputs 0 asynchronously. After release, no inst_done until a new load plus run.
